an_encoder_30bits: RTL and testbench

Sequential AN-code encoder: the transmit-side counterpart of the 30-bit SEC AN decoder. It accepts a 31-bit data word N and produces the codeword W = A·N (A = 83) over W_BITS = 38 bits using an iterative shift-and-add multiplier. An optional single arithmetic-weight error (±2^k) can be added to the codeword, so the pair can be tested end-to-end against the decoder's AWE table. It sits between the data source and the storage/channel model feeding the SEC decoder.

---
 rtl/an_encoder_30bits.sv | 149 ++++++++++++++
 tb/tb_an_encoder_30bits.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/an_encoder_30bits.sv
// an_encoder_30bits: sequential AN-code encoder, W = A * N.
//
// A shift-and-add multiplier builds the codeword one bit of A per cycle. It
// always runs the full A_BITS iterations. An optional single arithmetic-weight
// error (+/- 2^inj_pos) can be added to the codeword so that the matching SEC
// decoder can be exercised end-to-end.
//
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   in_valid / in_ready  input handshake for N and the injection fields
//   N                    data word (N_BITS)
//   inj_en               add an error to the codeword
//   inj_sign             0: +2^inj_pos, 1: -2^inj_pos
//   inj_pos              error bit position (POS_BITS)
//   out_valid/out_ready  output handshake for W
//   W                    codeword, possibly carrying the injected error
//   inj_flag             an error was actually applied to W
module an_encoder_30bits #(
  parameter int unsigned A        = 83,
  parameter int unsigned A_BITS   = 7,
  parameter int unsigned N_BITS   = 31,
  parameter int unsigned W_BITS   = 38,
  parameter int unsigned POS_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_BITS-1:0]   N,
  input  logic                inj_en,
  input  logic                inj_sign,
  input  logic [POS_BITS-1:0] inj_pos,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W_BITS-1:0]   W,
  output logic                inj_flag
);

  localparam int unsigned         CntW    = (A_BITS > 1) ? $clog2(A_BITS) : 1;
  localparam logic [A_BITS-1:0]   AVec    = A_BITS'(A);
  localparam logic [CntW-1:0]     CntLast = CntW'(A_BITS - 1);
  localparam logic [W_BITS-1:0]   WOne    = {{(W_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StMul, StInj, StDone} state_e;

  state_e                state_q, state_d;
  logic [N_BITS-1:0]     n_q, n_d;
  logic                  inj_en_q, inj_en_d;
  logic                  inj_sign_q, inj_sign_d;
  logic [POS_BITS-1:0]   inj_pos_q, inj_pos_d;
  logic [W_BITS-1:0]     acc_q, acc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [W_BITS-1:0]     w_q, w_d;
  logic                  flag_q, flag_d;
  logic                  out_valid_q, out_valid_d;

  logic [W_BITS-1:0]     addend;
  logic [W_BITS-1:0]     err;
  logic                  pos_ok;

  // Partial product for the current bit of A, formed at full codeword width.
  assign addend = {{(W_BITS-N_BITS){1'b0}}, n_q} << cnt_q;
  assign err    = WOne << inj_pos_q;
  // Positions beyond the codeword are silently ignored.
  assign pos_ok = (32'(inj_pos_q) < W_BITS);

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    inj_en_d    = inj_en_q;
    inj_sign_d  = inj_sign_q;
    inj_pos_d   = inj_pos_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    w_d         = w_q;
    flag_d      = flag_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          n_d        = N;
          inj_en_d   = inj_en;
          inj_sign_d = inj_sign;
          inj_pos_d  = inj_pos;
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = StMul;
        end
      end
      StMul: begin
        if (AVec[cnt_q]) acc_d = acc_q + addend;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StInj;
      end
      StInj: begin
        if (inj_en_q && pos_ok) begin
          // Modulo-2^W_BITS arithmetic gives the required wrap-around.
          w_d    = inj_sign_q ? (acc_q - err) : (acc_q + err);
          flag_d = 1'b1;
        end else begin
          w_d    = acc_q;
          flag_d = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        // A concurrent in_valid is left pending until IDLE.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      n_q         <= '0;
      inj_en_q    <= 1'b0;
      inj_sign_q  <= 1'b0;
      inj_pos_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      w_q         <= '0;
      flag_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      inj_en_q    <= inj_en_d;
      inj_sign_q  <= inj_sign_d;
      inj_pos_q   <= inj_pos_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      flag_q      <= flag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && rst_n;
  assign out_valid = out_valid_q;
  assign W         = w_q;
  assign inj_flag  = flag_q;

endmodule

// File: tb/tb_an_encoder_30bits.sv
// Directed self-checking bench for an_encoder_30bits.
module tb_an_encoder_30bits;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] N;
  logic        inj_en;
  logic        inj_sign;
  logic [5:0]  inj_pos;
  logic        out_valid;
  logic        out_ready;
  logic [37:0] W;
  logic        inj_flag;

  int total = 0;
  int bad   = 0;

  an_encoder_30bits dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .N         (N),
    .inj_en    (inj_en),
    .inj_sign  (inj_sign),
    .inj_pos   (inj_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .W         (W),
    .inj_flag  (inj_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word, measure latency and check the result, then complete the handshake.
  task automatic encode(input string tag, input logic [30:0] n, input logic en,
                        input logic sign, input logic [5:0] pos,
                        input logic [37:0] exp_w, input logic exp_flag);
    int cyc;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    N        = n;
    inj_en   = en;
    inj_sign = sign;
    inj_pos  = pos;
    step();
    in_valid = 1'b0;
    N        = '0;
    inj_en   = 1'b0;
    inj_pos  = '0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd8);
    check({tag, "_w"}, 64'(W), 64'(exp_w));
    check({tag, "_flag"}, 64'(inj_flag), 64'(exp_flag));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_w_keep"}, 64'(W), 64'(exp_w));
  endtask

  initial begin
    int t;
    logic [37:0] seen_w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    N         = '0;
    inj_en    = 1'b0;
    inj_sign  = 1'b0;
    inj_pos   = '0;
    step();
    step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_w", 64'(W), 64'd0);
    check("rst_flag", 64'(inj_flag), 64'd0);
    rst_n = 1'b1;
    #1;

    encode("min", 31'd1, 1'b0, 1'b0, 6'd0, 38'd83, 1'b0);
    encode("max", 31'h7fff_ffff, 1'b0, 1'b0, 6'd0, 38'd178241142701, 1'b0);
    encode("inj_pos", 31'd5, 1'b1, 1'b0, 6'd3, 38'd423, 1'b1);
    encode("inj_neg", 31'd5, 1'b1, 1'b1, 6'd0, 38'd414, 1'b1);
    encode("wrap", 31'd0, 1'b1, 1'b1, 6'd0, 38'h3f_ffff_ffff, 1'b1);
    encode("top_bit", 31'd0, 1'b1, 1'b0, 6'd37, 38'h20_0000_0000, 1'b1);
    encode("ignored", 31'd7, 1'b1, 1'b0, 6'd40, 38'd581, 1'b0);

    // Back-pressure: output held for 5 cycles with a competing input pending.
    in_valid = 1'b1;
    N        = 31'd10;
    step();
    N = 31'd2;
    t = 0;
    while (!out_valid && t < 20) begin
      step();
      t++;
    end
    check("bp_latency", 64'(t), 64'd8);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_w", 64'(W), 64'd830);
      check("bp_ov", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    // Simultaneous out_ready and in_valid: only the output handshake completes.
    out_ready = 1'b1;
    step();
    check("sim_ov", 64'(out_valid), 64'd0);
    check("sim_in_ready", 64'(in_ready), 64'd1);
    check("sim_w", 64'(W), 64'd830);

    // Throughput with out_ready tied high: accept N=2 now, next accept 10 cycles later.
    step();
    check("tp_busy", 64'(in_ready), 64'd0);
    N      = 31'd4;
    seen_w = '0;
    t      = 0;
    begin
      logic acc_now;
      acc_now = 1'b0;
      while (!acc_now && t < 30) begin
        acc_now = in_ready && in_valid;
        step();
        t++;
        if (out_valid) seen_w = W;
      end
    end
    in_valid = 1'b0;
    check("tp_w", 64'(seen_w), 64'd166);
    check("tp_period", 64'(t), 64'd10);
    t = 0;
    while (!out_valid && t < 20) begin
      step();
      t++;
    end
    check("tp2_latency", 64'(t), 64'd8);
    check("tp2_w", 64'(W), 64'd332);
    step();
    out_ready = 1'b0;

    // Reset during the 4th MUL cycle.
    in_valid = 1'b1;
    N        = 31'd100;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mr_in_ready_low", 64'(in_ready), 64'd0);
    step();
    check("mr_w", 64'(W), 64'd0);
    check("mr_ov", 64'(out_valid), 64'd0);
    check("mr_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("mr_hold_ov", 64'(out_valid), 64'd0);
    end
    rst_n = 1'b1;
    #1;
    encode("post_rst", 31'd3, 1'b0, 1'b0, 6'd0, 38'd249, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
